// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two read clients and two write clients sharing one
// 1R1W synchronous SRAM. Each port has its own two-client round-robin
// arbiter; a read that collides with the granted write on the same address
// is held off for a cycle so the write lands first.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              rd_valid,
    input  logic [2*ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]              rd_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    input  logic [1:0]              wr_valid,
    input  logic [2*ADDR_WIDTH-1:0] wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    output logic [1:0]              wr_ready,
    output logic                    sram_re,
    output logic [ADDR_WIDTH-1:0]   sram_radr,
    output logic                    sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_wadr,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;

    logic [1:0]            rd_win;
    logic [1:0]            wr_win;
    logic [ADDR_WIDTH-1:0] rd_addr_c0, rd_addr_c1, rd_addr_sel;
    logic [ADDR_WIDTH-1:0] wr_addr_c0, wr_addr_c1, wr_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;
    logic                  collision;

    // Unpack per-client address and data fields.
    always_comb begin
        rd_addr_c0 = rd_addr[0 +: ADDR_WIDTH];
        rd_addr_c1 = rd_addr[ADDR_WIDTH +: ADDR_WIDTH];
        wr_addr_c0 = wr_addr[0 +: ADDR_WIDTH];
        wr_addr_c1 = wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Round-robin winners: the pointed-to client first, the other only if the preferred one is idle.
    always_comb begin
        rd_win = '0;
        if (rd_valid[rd_ptr_q]) begin
            rd_win[rd_ptr_q] = 1'b1;
        end else if (rd_valid[~rd_ptr_q]) begin
            rd_win[~rd_ptr_q] = 1'b1;
        end
        wr_win = '0;
        if (wr_valid[wr_ptr_q]) begin
            wr_win[wr_ptr_q] = 1'b1;
        end else if (wr_valid[~wr_ptr_q]) begin
            wr_win[~wr_ptr_q] = 1'b1;
        end
    end

    // Select the winning client's fields and detect a same-address read/write collision.
    always_comb begin
        rd_addr_sel = rd_win[1] ? rd_addr_c1 : rd_addr_c0;
        wr_addr_sel = wr_win[1] ? wr_addr_c1 : wr_addr_c0;
        wr_data_sel = wr_win[1] ? wr_data[DATA_WIDTH +: DATA_WIDTH]
                                : wr_data[0 +: DATA_WIDTH];
        collision   = (|rd_win) && (|wr_win) && (rd_addr_sel == wr_addr_sel);
    end

    // Handshake and SRAM pin outputs; everything is forced idle while reset is held.
    always_comb begin
        rd_ready  = '0;
        wr_ready  = '0;
        if (!rst) begin
            wr_ready = wr_win;
            rd_ready = collision ? 2'b00 : rd_win;
        end
        sram_re   = |rd_ready;
        sram_radr = rd_addr_sel;
        sram_we   = |wr_ready;
        sram_wadr = wr_addr_sel;
        sram_d    = wr_data_sel;
        rsp_valid = rsp_valid_q;
        rsp_data  = sram_q;
    end

    // Next-state: pointers move past the granted client, response valid tracks last read accept.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_ready[0]) begin
            rd_ptr_d = 1'b1;
        end else if (rd_ready[1]) begin
            rd_ptr_d = 1'b0;
        end
        wr_ptr_d = wr_ptr_q;
        if (wr_ready[0]) begin
            wr_ptr_d = 1'b1;
        end else if (wr_ready[1]) begin
            wr_ptr_d = 1'b0;
        end
        rsp_valid_d = rd_ready;
    end

    // State registers with asynchronous reset; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the arbiter and the SRAM.
module tb_sram_port_arbiter;

    localparam int DW = 128;
    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      rd_valid;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]      rd_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      wr_valid;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]      wr_ready;
    logic            sram_re;
    logic [AW-1:0]   sram_radr;
    logic            sram_we;
    logic [AW-1:0]   sram_wadr;
    logic [DW-1:0]   sram_d;
    logic [DW-1:0]   sram_q;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .sram_re(sram_re), .sram_radr(sram_radr), .sram_we(sram_we),
        .sram_wadr(sram_wadr), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Synchronous 1R1W SRAM: write commits and read data registers on the rising edge.
    logic [DW-1:0] ram [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        sram_q = '0;
    end
    always @(posedge clk) begin
        if (sram_we) ram[sram_wadr] <= sram_d;
        if (sram_re) sram_q <= ram[sram_radr];
    end

    // Reference model state
    logic [DW-1:0] mdl_mem [0:DEPTH-1];
    int            mdl_rd_ptr, mdl_wr_ptr;
    logic [1:0]    exp_rsp_valid;
    logic [DW-1:0] exp_rsp_data;

    int            last_rg, last_wg;
    logic [1:0]    obs_rsp_valid;
    logic [DW-1:0] obs_rsp_data;
    logic          obs_re, obs_we;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int ptr);
        if (v[ptr]) return ptr;
        if (v[1-ptr]) return 1 - ptr;
        return -1;
    endfunction

    function automatic logic [AW-1:0] ra(input int c);
        logic [2*AW-1:0] t = rd_addr;
        return (c == 1) ? t[2*AW-1:AW] : t[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] wa(input int c);
        logic [2*AW-1:0] t = wr_addr;
        return (c == 1) ? t[2*AW-1:AW] : t[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] wd(input int c);
        logic [2*DW-1:0] t = wr_data;
        return (c == 1) ? t[2*DW-1:DW] : t[DW-1:0];
    endfunction

    // One clock cycle: inputs already driven just after the edge; check at the falling edge.
    task automatic step();
        int rg, wg;
        logic [1:0] erd, ewr;
        #4;
        rg = pick(rd_valid, mdl_rd_ptr);
        wg = pick(wr_valid, mdl_wr_ptr);
        if (rg >= 0 && wg >= 0 && ra(rg) == wa(wg)) rg = -1;
        if (rst) begin
            rg = -1;
            wg = -1;
            exp_rsp_valid = 2'b00;
        end
        erd = (rg < 0) ? 2'b00 : 2'(1 << rg);
        ewr = (wg < 0) ? 2'b00 : 2'(1 << wg);
        check("rd_ready", rd_ready, erd);
        check("wr_ready", wr_ready, ewr);
        check("sram_re", sram_re, |erd);
        check("sram_we", sram_we, |ewr);
        if (rg >= 0) check("sram_radr", sram_radr, ra(rg));
        if (wg >= 0) begin
            check("sram_wadr", sram_wadr, wa(wg));
            check("sram_d", sram_d, wd(wg));
        end
        check("rsp_valid", rsp_valid, exp_rsp_valid);
        if (exp_rsp_valid != 2'b00) check("rsp_data", rsp_data, exp_rsp_data);
        obs_rsp_valid = rsp_valid;
        obs_rsp_data  = rsp_data;
        obs_re        = sram_re;
        obs_we        = sram_we;
        last_rg = rg;
        last_wg = wg;
        @(posedge clk);
        if (rst) begin
            mdl_rd_ptr    = 0;
            mdl_wr_ptr    = 0;
            exp_rsp_valid = 2'b00;
        end else begin
            exp_rsp_valid = erd;
            if (rg >= 0) begin
                exp_rsp_data = mdl_mem[ra(rg)];
                mdl_rd_ptr   = 1 - rg;
            end
            if (wg >= 0) begin
                mdl_mem[wa(wg)] = wd(wg);
                mdl_wr_ptr      = 1 - wg;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid = '0;
        wr_valid = '0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] pat;

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        mdl_rd_ptr    = 0;
        mdl_wr_ptr    = 0;
        exp_rsp_valid = '0;
        exp_rsp_data  = '0;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Write then read of address 0 with all-ones data
        wr_valid = 2'b01; wr_addr = '0; wr_data = {{DW{1'b0}}, {DW{1'b1}}};
        step();
        check("t_wr_rd_wgrant", last_wg, 0);
        idle_inputs();
        rd_valid = 2'b10; rd_addr = '0;
        step();
        check("t_wr_rd_rgrant", last_rg, 1);
        idle_inputs();
        step();
        check("t_wr_rd_rspv", obs_rsp_valid, 2'b10);
        check("t_wr_rd_data", obs_rsp_data, {DW{1'b1}});

        // Fairness: two readers held valid for 6 cycles
        do_reset();
        wr_valid = 2'b11;
        wr_addr  = {AW'(12'h020), AW'(12'h010)};
        wr_data  = {{DW/8{8'hB1}}, {DW/8{8'hA0}}};
        step();
        step();
        idle_inputs();
        rd_valid = 2'b11;
        rd_addr  = {AW'(12'h020), AW'(12'h010)};
        for (int i = 0; i < 6; i++) begin
            step();
            check("t_fair_grant", last_rg, i % 2);
            if (i > 0) check("t_fair_rspv", obs_rsp_valid, (i % 2 == 1) ? 2'b01 : 2'b10);
        end
        idle_inputs();
        step();
        check("t_fair_last_data", obs_rsp_data, {DW/8{8'hB1}});

        // Collision on address 0x005
        do_reset();
        pat = rand_word();
        rd_valid = 2'b01; rd_addr = {AW'(0), AW'(12'h005)};
        wr_valid = 2'b10; wr_addr = {AW'(12'h005), AW'(0)}; wr_data = {pat, {DW{1'b0}}};
        step();
        check("t_col_rd", last_rg, -1);
        check("t_col_wr", last_wg, 1);
        check("t_col_re", obs_re, 1'b0);
        wr_valid = 2'b00;
        step();
        check("t_col_rd_next", last_rg, 0);
        idle_inputs();
        step();
        check("t_col_data", obs_rsp_data, pat);

        // Concurrency: all four clients, distinct addresses
        do_reset();
        rd_valid = 2'b11; rd_addr = {AW'(12'h101), AW'(12'h100)};
        wr_valid = 2'b11; wr_addr = {AW'(12'h201), AW'(12'h200)};
        wr_data  = {rand_word(), rand_word()};
        for (int i = 0; i < 4; i++) begin
            step();
            check("t_conc_re", obs_re, 1'b1);
            check("t_conc_we", obs_we, 1'b1);
            check("t_conc_rg", last_rg, i % 2);
            check("t_conc_wg", last_wg, i % 2);
        end

        // Reset during an outstanding read
        do_reset();
        rd_valid = 2'b01; rd_addr = {AW'(0), AW'(12'h010)};
        step();
        check("t_rst_accept", last_rg, 0);
        idle_inputs();
        rst = 1'b1;
        step();
        check("t_rst_rspv_in", obs_rsp_valid, 2'b00);
        rst = 1'b0;
        step();
        check("t_rst_rspv_after", obs_rsp_valid, 2'b00);
        rd_valid = 2'b11; rd_addr = {AW'(12'h020), AW'(12'h010)};
        step();
        check("t_rst_prio", last_rg, 0);

        // Idle for 10 cycles with both pointers moved to client 1
        do_reset();
        rd_valid = 2'b11; rd_addr = {AW'(12'h031), AW'(12'h030)};
        wr_valid = 2'b11; wr_addr = {AW'(12'h041), AW'(12'h040)};
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            step();
            check("t_idle_re", obs_re, 1'b0);
            check("t_idle_we", obs_we, 1'b0);
        end
        rd_valid = 2'b11; rd_addr = {AW'(12'h031), AW'(12'h030)};
        wr_valid = 2'b11; wr_addr = {AW'(12'h041), AW'(12'h040)};
        step();
        check("t_idle_rptr", last_rg, 1);
        check("t_idle_wptr", last_wg, 1);

        // Randomized traffic on a small address window to provoke collisions
        idle_inputs();
        step();
        for (int n = 0; n < 3000; n++) begin
            logic [2*AW-1:0] ra_n, wa_n;
            logic [2*DW-1:0] wd_n;
            ra_n = rd_addr;
            wa_n = wr_addr;
            wd_n = wr_data;
            for (int c = 0; c < 2; c++) begin
                if (!(rd_valid[c] && last_rg != c) || n % 97 == 0) begin
                    rd_valid[c] = ($urandom_range(0, 9) < 6);
                    ra_n[c*AW +: AW] = AW'($urandom_range(0, 7));
                end
                if (!(wr_valid[c] && last_wg != c) || n % 97 == 0) begin
                    wr_valid[c] = ($urandom_range(0, 9) < 6);
                    wa_n[c*AW +: AW] = AW'($urandom_range(0, 7));
                    wd_n[c*DW +: DW] = rand_word();
                end
            end
            rd_addr = ra_n;
            wr_addr = wa_n;
            wr_data = wd_n;
            rst = (n % 500 == 499);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 128, SRAM word width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 12, SRAM address width; depth 2**ADDR_WIDTH.
REQ-003 The module SHALL have port clk  input  1  single clock; every register is clocked on the rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The module SHALL have port rd_valid  input  2  read request valid, one bit per read client (client 0 = bit 0).
REQ-006 The module SHALL have port rd_addr  input  2*ADDR_WIDTH  read addresses; client i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 The module SHALL have port rd_ready  output  2  read request accepted this cycle, one-hot or zero.
REQ-008 The module SHALL have port rsp_valid  output  2  read data valid for client i, one-hot or zero.
REQ-009 The module SHALL have port rsp_data  output  DATA_WIDTH  read data, shared by both clients.
REQ-010 The module SHALL have port wr_valid  input  2  write request valid per write client.
REQ-011 The module SHALL have port wr_addr  input  2*ADDR_WIDTH  write addresses, packed as for rd_addr.
REQ-012 The module SHALL have port wr_data  input  2*DATA_WIDTH  write data; client i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 The module SHALL have port wr_ready  output  2  write request accepted this cycle, one-hot or zero.
REQ-014 The module SHALL have ports sram_re (output, 1), sram_radr (output, ADDR_WIDTH), sram_we (output, 1), sram_wadr (output, ADDR_WIDTH) and sram_d (output, DATA_WIDTH), driving the re, radr, we, wadr and d pins of ccs_ram_sync_1R1W.
REQ-015 The module SHALL have port sram_q  input  DATA_WIDTH  driven by the q pin of ccs_ram_sync_1R1W.

Function
REQ-016 A request SHALL transfer in a cycle where valid and ready are both 1.
REQ-017 ready SHALL depend combinationally on valid, address and arbitration state only.
REQ-018 A client SHALL hold valid, address and data stable until it is accepted.
REQ-019 The read port and the write port SHALL each have an independent two-client round-robin arbiter with a 1-bit priority pointer.
REQ-020 Each pointer SHALL select the preferred client; the other client is granted only when the preferred client is not valid.
REQ-021 After a grant to client i, the pointer of that port SHALL move to client 1-i; with no grant, the pointer SHALL hold.
REQ-022 sram_we SHALL equal OR(wr_ready), with sram_wadr and sram_d muxed from the granted write client; sram_wadr and sram_d are don't-care when sram_we=0.
REQ-023 sram_re SHALL equal OR(rd_ready), with sram_radr muxed from the granted read client.
REQ-024 Collision: if the read winner and the write winner are both valid and target the same address, the read grant SHALL be suppressed that cycle, the write proceeds, and the read pointer holds.
REQ-025 Read latency SHALL be exactly 1 cycle: rsp_valid[i] is registered as rd_ready[i] of the previous cycle.
REQ-026 rsp_data SHALL equal sram_q unmodified, with no registering.
REQ-027 Responses SHALL have no backpressure; a client must consume data in the cycle rsp_valid is 1.
REQ-028 A read issued one cycle after a write to the same address SHALL return the new data, since the write commits at the edge on which it is accepted.
REQ-029 Back-to-back accepts every cycle SHALL be supported on both ports concurrently, giving one read and one write per cycle maximum.

Reset
REQ-030 While rst=1, both pointers SHALL be 0, rsp_valid SHALL be 2'b00, and rd_ready, wr_ready, sram_re and sram_we SHALL be 0.
REQ-031 Assertion of rst during an outstanding read SHALL discard that response: no rsp_valid pulse after reset is released.
REQ-032 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-033 Write then read: write client 0 writes addr 0x000 with all-ones data; the next cycle read client 1 reads 0x000 -> rd_ready=2'b10, and one cycle later rsp_valid=2'b10 and rsp_data=all-ones.
REQ-034 Fairness: both read clients hold valid for 6 cycles with addresses 0x010 and 0x020 -> grants alternate 0,1,0,1,0,1, and each rsp_valid pulse carries that client's data.
REQ-035 Collision: read client 0 and write client 1 both target 0x005 in the same cycle -> wr_ready=2'b10, rd_ready=2'b00 and sram_re=0; the read is accepted the next cycle and returns the newly written word.
REQ-036 Concurrency: all four clients are valid with distinct addresses for 4 cycles -> sram_re=sram_we=1 every cycle, and each port alternates between its clients.
REQ-037 Reset mid-read: rst is asserted in the cycle after rd_ready=2'b01 -> rsp_valid stays 2'b00, and after release client 0 has priority again.
REQ-038 Idle: all valid inputs are 0 for 10 cycles -> sram_re=sram_we=0, rsp_valid=2'b00, and the pointers are unchanged.
